// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and width helpers.
package apb_pkg;

  // One-hot FSM states, same encoding style as the APB master.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    WAIT = 3'b010,
    DONE = 3'b100
  } apb_state_e;

  // Default-configuration widths.
  localparam int STRB_W = 32 / 8;
  localparam int IDX_W  = 4;

  // Byte-strobe width for a given data bus width.
  function automatic int strb_w(input int data_width);
    return data_width / 8;
  endfunction

  // Word-index width for a given register count.
  function automatic int idx_w(input int num_regs);
    return $clog2(num_regs);
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Byte-enabled register bank: sync write, async read, index 0 reads a constant ID.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001,
  localparam int                   SW         = strb_w(DATA_WIDTH),
  localparam int                   IW         = idx_w(NUM_REGS)
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  we,
  input  logic [IW-1:0]         widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [SW-1:0]         wstrb,
  input  logic [IW-1:0]         ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // Per-byte-lane write; slot 0 is never written so it stays a constant.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      regs <= '0;
    end else if (we && (widx != '0)) begin
      for (int b = 0; b < SW; b++) begin
        if (wstrb[b]) regs[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Asynchronous read, ID value at index 0.
  always_comb begin
    rdata = regs[ridx];
    if (ridx == '0) rdata = ID_VALUE;
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with programmable wait states, decode errors and a register bank.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001,
  parameter int                    PROT_CHECK  = 1,
  localparam int                   SW          = strb_w(DATA_WIDTH),
  localparam int                   IW          = idx_w(NUM_REGS)
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [SW-1:0]         PSTRB,
  input  logic [2:0]            PPROT,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  apb_state_e            state_q, state_n;
  logic [3:0]            cnt_q, cnt_n;
  logic [IW-1:0]         idx_q, idx_now, rd_idx;
  logic                  write_q, err_q, err_now;
  logic [DATA_WIDTH-1:0] wdata_q, rdata;
  logic [SW-1:0]         strb_q;
  logic                  setup, done_in, sel_err, sel_wr, we;
  logic                  pready_q, pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  // Top two address bits are the master's slave select; PPROT[2:1] carry no meaning here.
  logic                  unused_bits;
  assign unused_bits = ^{PADDR[ADDR_WIDTH-1 -: 2], PPROT};

  assign setup = PSEL && !PENABLE;

  // Decode of the live bus; only consumed during the setup phase.
  always_comb begin
    idx_now = PADDR[IW+1:2];
    err_now = (PADDR[1:0] != 2'b00)
           || (|PADDR[ADDR_WIDTH-3:IW+2])
           || (PWRITE && (idx_now == '0))
           || ((PROT_CHECK != 0) && !PPROT[0]);
  end

  // FSM next state and wait counter.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          cnt_n = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) state_n = DONE;
          else                  state_n = WAIT;
        end
      end
      WAIT: begin
        if (!PSEL)              state_n = IDLE;
        else if (cnt_q <= 4'd1) state_n = DONE;
        else                    cnt_n   = cnt_q - 4'd1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Capture the transfer at setup; later bus changes are ignored.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if ((state_q == IDLE) && setup) begin
      idx_q   <= idx_now;
      write_q <= PWRITE;
      err_q   <= err_now;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end

  // With zero wait states DONE is entered straight from IDLE, so use the live decode.
  always_comb begin
    done_in = (state_n == DONE);
    sel_err = (state_q == IDLE) ? err_now : err_q;
    sel_wr  = (state_q == IDLE) ? PWRITE  : write_q;
    rd_idx  = (state_q == IDLE) ? idx_now : idx_q;
  end

  // Commit only on the edge closing a completed, error-free write.
  assign we = (state_q == DONE) && PSEL && PENABLE && write_q && !err_q;

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .we      (we),
    .widx    (idx_q),
    .wdata   (wdata_q),
    .wstrb   (strb_q),
    .ridx    (rd_idx),
    .rdata   (rdata)
  );

  // Registered response: valid only in the DONE cycle, zero otherwise.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= done_in;
      pslverr_q <= done_in && sel_err;
      prdata_q  <= (done_in && !sel_err && !sel_wr) ? rdata : '0;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: scoreboard of expected responses popped on PREADY.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA9B0_0001;
  localparam int          WC = 2;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;

  int          checks   = 0;
  int          failures = 0;
  logic [32:0] sbq[$];
  logic [31:0] model[16];

  apb_slave_regfile dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PPROT   (PPROT),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every PREADY pulse must match the oldest expectation.
  always @(negedge PCLK) begin : mon
    logic [32:0] e;
    if (PRESETn) begin
      if (PREADY) begin
        if (sbq.size() == 0) chk("unexp_ready", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("sb_rdata", PRDATA, e[31:0]);
          chk("sb_err", {31'b0, PSLVERR}, {31'b0, e[32]});
        end
      end else begin
        chk("idle_zero", PRDATA | {31'b0, PSLVERR}, 32'd0);
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  // One complete transfer; expectation derived from the bench model.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rd, output logic er);
    logic [3:0]  idx;
    logic        e;
    logic [31:0] exp_d;
    logic        seen;
    int          n;
    idx   = addr[5:2];
    e     = (addr[1:0] != 2'b00) || (addr[29:6] != '0) || (wr && idx == 4'd0) || !prot[0];
    exp_d = '0;
    if (!e && !wr) exp_d = (idx == 4'd0) ? ID : model[idx];
    sbq.push_back({e, exp_d});
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wdata; PSTRB = strb; PPROT = prot;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    n = 0; seen = 1'b0; rd = '0; er = 1'b0;
    while (!seen && n <= 40) begin
      @(negedge PCLK);
      if (PREADY) begin
        seen = 1'b1; rd = PRDATA; er = PSLVERR;
      end else n++;
    end
    if (!seen) begin
      chk("timeout", 32'd1, 32'd0);
      if (sbq.size() != 0) sbq.delete(sbq.size() - 1);
    end
    chk("latency", 32'(n), 32'(WC));
    if (!e && wr)
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = wdata[b*8 +: 8];
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb,
                        input logic [2:0] prot, output logic er);
    logic [31:0] rd;
    xfer(1'b1, addr, d, strb, prot, rd, er);
  endtask

  task automatic rd_reg(input logic [31:0] addr, output logic [31:0] rd, output logic er);
    xfer(1'b0, addr, 32'h0, 4'h0, 3'b001, rd, er);
  endtask

  initial begin
    logic [31:0] d;
    logic        er;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = 3'b001;
    model_clear();
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_pready", {31'b0, PREADY}, 32'd0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Full write then back-to-back readback.
    wr_reg(32'h04, 32'hDEADBEEF, 4'hF, 3'b001, er);
    chk("wr04_err", {31'b0, er}, 32'd0);
    rd_reg(32'h04, d, er);
    chk("rd04", d, 32'hDEADBEEF);

    // Partial strobes over prior contents.
    wr_reg(32'h08, 32'hAABBCCDD, 4'hF, 3'b001, er);
    wr_reg(32'h08, 32'h11223344, 4'b0101, 3'b001, er);
    rd_reg(32'h08, d, er);
    chk("rd08_strb", d, 32'hAA22CC44);

    // ID register is read-only.
    rd_reg(32'h00, d, er);
    chk("rd_id", d, ID);
    wr_reg(32'h00, 32'h0, 4'hF, 3'b001, er);
    chk("wr_id_err", {31'b0, er}, 32'd1);
    rd_reg(32'h00, d, er);
    chk("rd_id_again", d, ID);

    // Out of range and misaligned.
    rd_reg(32'h40, d, er);
    chk("rd40_err", {31'b0, er}, 32'd1);
    chk("rd40_data", d, 32'd0);
    wr_reg(32'h06, 32'h0BAD0BAD, 4'hF, 3'b001, er);
    chk("wr06_err", {31'b0, er}, 32'd1);
    rd_reg(32'h04, d, er);
    chk("rd04_unchanged", d, 32'hDEADBEEF);

    // Privilege check.
    wr_reg(32'h0C, 32'h12345678, 4'hF, 3'b000, er);
    chk("wr0c_unpriv_err", {31'b0, er}, 32'd1);
    rd_reg(32'h0C, d, er);
    chk("rd0c_unwritten", d, 32'd0);
    wr_reg(32'h0C, 32'h12345678, 4'hF, 3'b001, er);
    chk("wr0c_priv_err", {31'b0, er}, 32'd0);
    rd_reg(32'h0C, d, er);
    chk("rd0c", d, 32'h12345678);

    // Upper address bits: middle bits error, top select bits ignored.
    rd_reg(32'h0000_1004, d, er);
    chk("rd_hi_err", {31'b0, er}, 32'd1);
    rd_reg(32'hC000_0004, d, er);
    chk("rd_sel_bits", d, 32'hDEADBEEF);

    // Zero-strobe write is a legal no-op.
    wr_reg(32'h04, 32'h0, 4'h0, 3'b001, er);
    chk("wr_nostrb_err", {31'b0, er}, 32'd0);
    rd_reg(32'h04, d, er);
    chk("rd04_nostrb", d, 32'hDEADBEEF);

    // Access phase without setup is ignored.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'hFFFF_FFFF;
    PSTRB = 4'hF; PPROT = 3'b001;
    repeat (3) begin
      @(negedge PCLK);
      chk("nosetup_ready", {31'b0, PREADY}, 32'd0);
    end
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;

    // Abort by dropping PSEL in WAIT.
    wr_reg(32'h10, 32'h0000_0055, 4'hF, 3'b001, er);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h0000_00FF;
    PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_t1_ready", {31'b0, PREADY}, 32'd0);
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      chk("abort_ready", {31'b0, PREADY}, 32'd0);
    end
    @(posedge PCLK); #1;
    rd_reg(32'h10, d, er);
    chk("rd10_abort", d, 32'h0000_0055);

    // Reset in the middle of WAIT.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'h1212_1212;
    PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    chk("rstmid_pready", {31'b0, PREADY}, 32'd0);
    chk("rstmid_pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("rstmid_prdata", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    model_clear();
    @(posedge PCLK); #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    rd_reg(32'h04, d, er);
    chk("rd04_after_rst", d, 32'd0);
    rd_reg(32'h08, d, er);
    chk("rd08_after_rst", d, 32'd0);

    repeat (2) @(posedge PCLK);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB3/APB4 completer (slave) answering one PSELx line of the existing APB master.
- Holds a bank of NUM_REGS word-wide registers with a fixed ID register at index 0.
- Inserts a programmable number of wait states and reports errors through PSLVERR.
- Byte-lane writes through PSTRB; privilege checking through PPROT.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, address bus width in bits.
- NUM_REGS, 16, number of registers; power of two, 2 to 256.
- WAIT_CYCLES, 2, wait states inserted before PREADY; 0 to 15.
- ID_VALUE, 32'hA9B0_0001, read-only contents of register 0.
- PROT_CHECK, 1, when 1, unprivileged accesses (PPROT[0]=0) are errored.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  select (one bit of the master's PSELx).
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PPROT  in  3  protection attributes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.

Behaviour:
- Reset: PREADY, PSLVERR and PRDATA are 0. FSM is in IDLE. Registers 1..NUM_REGS-1 are 0. Reset mid-transfer aborts it with no write.
- FSM states are IDLE, WAIT and DONE, one-hot encoded.
- IDLE:
  - Setup phase (PSEL=1, PENABLE=0) latches PADDR, PWRITE, PWDATA, PSTRB and the error flag.
  - Counter loads WAIT_CYCLES. Next state is WAIT, or DONE if WAIT_CYCLES=0.
- WAIT: counter decrements each cycle while PSEL=1. Go to DONE when the counter reaches 1.
- DONE:
  - PREADY=1 for exactly one cycle, in cycle T1+WAIT_CYCLES, where T1 is the first access cycle.
  - PSLVERR and PRDATA are valid in the same cycle. Next state is IDLE.
- Outputs are registered, so PREADY never depends combinationally on inputs.
- Write commit happens on the rising edge that ends the DONE cycle, only if PSEL=PENABLE=1 and there is no error.
  - Byte lane i is updated only when PSTRB[i]=1.
  - PSTRB=0 is a legal write: no change, no error.
- Read: PRDATA = register contents in the DONE cycle. PRDATA=0 in every other cycle and on error. PSTRB is ignored.
- Error (PSLVERR=1) is raised by any of the following; the write is suppressed:
  - PADDR[1:0] != 0 (misaligned).
  - Word index >= NUM_REGS.
  - Address bits above the index and below bit ADDR_WIDTH-2 are nonzero. The top two bits are the master's slave select and are ignored.
  - A write to register 0.
  - PROT_CHECK=1 and PPROT[0]=0.
- Abort: if PSEL falls in WAIT or DONE, return to IDLE. No write, outputs 0.
- Back-to-back: a setup phase may occur in the cycle after DONE; there is no dead cycle.
- The latched address is used throughout. PADDR changes after the setup phase are ignored.
- An access phase seen in IDLE without a preceding setup is ignored; PREADY stays 0.

Decomposition:
- Shared package apb_pkg holds:
  - FSM state localparams (IDLE=3'b001, WAIT=3'b010, DONE=3'b100), matching the master's encoding style.
  - Width helper constants (STRB_W = DATA_WIDTH/8, IDX_W = clog2(NUM_REGS)).
- Sub-module apb_regfile:
  - Byte-enabled storage with synchronous write port and asynchronous read port.
  - Register 0 is hard-wired to ID_VALUE.
- apb_slave_regfile holds the FSM, wait counter, decode/error logic and output registers.

Test Plan:
- Write 0xDEADBEEF to 0x04 with PSTRB=4'hF, WAIT_CYCLES=2. PREADY is high in T1+2, PSLVERR=0. A following read of 0x04 returns 0xDEADBEEF in its DONE cycle.
- Write 0x11223344 to 0x08 with PSTRB=4'b0101 over prior contents 0xAABBCCDD. Readback is 0xAA22CC44.
- Read 0x00 returns ID_VALUE. Write 0x0 to 0x00 gives PSLVERR=1, and a later read still returns ID_VALUE.
- Read 0x40 (index 16 >= NUM_REGS) gives PSLVERR=1, PRDATA=0. Write to 0x06 (misaligned) gives PSLVERR=1 and the register is unchanged.
- With PROT_CHECK=1, a write to 0x0C with PPROT=3'b000 gives PSLVERR=1, no write. The same write with PPROT=3'b001 succeeds.
- Start a write to 0x10, then drop PSEL in WAIT: no PREADY, register unchanged. Assert PRESETn=0 mid-WAIT: outputs are 0 immediately and register 0x04 reads back 0.
